// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Opcode/funct values, datapath select encodings and the FSM state type.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_IRQ
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [2:0] PCSRC_PC4    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_REG    = 3'b011;
  localparam logic [2:0] PCSRC_IRQ    = 3'b100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_K0 = 2'b11;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;
  localparam logic [2:0] ALU_UPPER = 3'd7;

  typedef struct packed {
    logic       pc_write;
    logic [2:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       ext_op;
    logic       lu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational OpCode/Funct classifier feeding the multi-cycle FSM.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [5:0]         op_code,
  input  logic [5:0]         funct,
  output logic               is_rtype,
  output logic               is_branch,
  output logic               is_load,
  output logic               is_store,
  output logic               is_jump,
  output logic               is_jal,
  output logic               is_jr,
  output logic               is_jalr,
  output logic               is_shift,
  output logic               is_imm,
  output logic               illegal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ext_op,
  output logic               lu_op
);

  logic [2:0] alu3;
  logic       zero_ext;

  always_comb begin
    is_rtype  = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jump   = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_jalr   = 1'b0;
    is_shift  = 1'b0;
    is_imm    = 1'b0;
    illegal   = 1'b0;
    lu_op     = 1'b0;
    zero_ext  = 1'b0;
    alu3      = ALU_ADD;
    case (op_code)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        alu3     = ALU_FUNCT;
        is_jr    = (funct == FN_JR);
        is_jalr  = (funct == FN_JALR);
        is_shift = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        is_branch = 1'b1;
        alu3      = ALU_SUB;
      end
      OP_J:     is_jump = 1'b1;
      OP_JAL:   is_jal  = 1'b1;
      OP_ADDI, OP_ADDIU: is_imm = 1'b1;
      OP_SLTI:  begin is_imm = 1'b1; alu3 = ALU_SLT;  end
      OP_SLTIU: begin is_imm = 1'b1; alu3 = ALU_SLTU; end
      OP_ANDI:  begin is_imm = 1'b1; alu3 = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:   begin is_imm = 1'b1; alu3 = ALU_OR;  zero_ext = 1'b1; end
      OP_LUI:   begin is_imm = 1'b1; alu3 = ALU_UPPER; lu_op = 1'b1; end
      OP_LW:    is_load  = 1'b1;
      OP_SW:    is_store = 1'b1;
      default:  illegal  = 1'b1;
    endcase
  end

  // Logical immediates are the only zero-extended ones; unsupported opcodes drive nothing.
  assign ext_op = !illegal && !zero_ext;
  assign alu_op = illegal ? '0 : ALUOP_W'(alu3);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing, interrupt entry,
// memory handshake and retired-instruction counting.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter int CNT_W         = 32,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               IRQ,
  input  logic               mem_ready,
  input  logic               branch_taken,
  output logic               PCWrite,
  output logic [2:0]         PCSrc,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemToReg,
  output logic               ALUSrc1,
  output logic               ALUSrc2,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               irq_mask,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  state_e             state_q, state_d;
  logic               irq_mask_q, irq_mask_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  ctrl_t              ctrl;
  logic [ALUOP_W-1:0] alu_op_out;
  logic               retire, to_if, mem_go;

  logic d_rtype, d_branch, d_load, d_store, d_jump, d_jal, d_jr, d_jalr;
  logic d_shift, d_imm, d_illegal, d_ext, d_lu;
  logic [ALUOP_W-1:0] d_alu_op;

  ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .op_code   (OpCode),
    .funct     (Funct),
    .is_rtype  (d_rtype),
    .is_branch (d_branch),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_jump   (d_jump),
    .is_jal    (d_jal),
    .is_jr     (d_jr),
    .is_jalr   (d_jalr),
    .is_shift  (d_shift),
    .is_imm    (d_imm),
    .illegal   (d_illegal),
    .alu_op    (d_alu_op),
    .ext_op    (d_ext),
    .lu_op     (d_lu)
  );

  assign mem_go = USE_MEM_READY ? mem_ready : 1'b1;

  always_comb begin
    state_d    = state_q;
    irq_mask_d = irq_mask_q;
    retire     = 1'b0;
    to_if      = 1'b0;
    ctrl       = '0;
    alu_op_out = '0;
    case (state_q)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        if (mem_go) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_PC4;
          state_d       = S_ID;
        end
      end
      S_ID: begin
        if (d_illegal) begin
          ctrl.illegal = 1'b1;
          to_if        = 1'b1;
        end else if (d_jump || d_jal) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_JUMP;
          if (d_jal) begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = REGDST_RA;
            ctrl.mem_to_reg = MEMTOREG_PC;
          end
          retire = 1'b1;
          to_if  = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (d_branch) begin
          ctrl.pc_write = branch_taken;
          ctrl.pc_src   = PCSRC_BRANCH;
          retire        = 1'b1;
          to_if         = 1'b1;
        end else if (d_jr || d_jalr) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_REG;
          if (d_jalr) begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = REGDST_RD;
            ctrl.mem_to_reg = MEMTOREG_PC;
          end
          if (d_jr) irq_mask_d = 1'b0;
          retire = 1'b1;
          to_if  = 1'b1;
        end else if (d_load || d_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = d_load;
        ctrl.mem_write = d_store;
        if (mem_go) begin
          if (d_load) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
            to_if  = 1'b1;
          end
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = d_rtype ? REGDST_RD : REGDST_RT;
        ctrl.mem_to_reg = d_load ? MEMTOREG_MDR : MEMTOREG_ALU;
        retire          = 1'b1;
        to_if           = 1'b1;
      end
      S_IRQ: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_K0;
        ctrl.mem_to_reg = MEMTOREG_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_IRQ;
        irq_mask_d      = 1'b1;
        to_if           = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    // Checking against the next mask lets a jr return straight into a pending IRQ.
    if (to_if) state_d = (IRQ && !irq_mask_d) ? S_IRQ : S_IF;
    instr_count_d = instr_count_q + CNT_W'(retire);

    if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
      ctrl.alu_src1 = d_shift;
      ctrl.alu_src2 = d_imm || d_load || d_store;
      ctrl.ext_op   = d_ext;
      ctrl.lu_op    = d_lu;
      alu_op_out    = d_alu_op;
    end

    if (!reset) begin
      ctrl       = '0;
      alu_op_out = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IF;
      irq_mask_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      irq_mask_q    <= irq_mask_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCSrc       = ctrl.pc_src;
  assign IorD        = ctrl.iord;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign ALUSrc1     = ctrl.alu_src1;
  assign ALUSrc2     = ctrl.alu_src2;
  assign ExtOp       = ctrl.ext_op;
  assign LuOp        = ctrl.lu_op;
  assign illegal     = ctrl.illegal;
  assign ALUOp       = alu_op_out;
  assign irq_mask    = irq_mask_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each driven cycle queues its
// hand-computed strobe vector, and a negedge monitor pops and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic [2:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       ext_op;
    logic       lu_op;
    logic [2:0] alu_op;
    logic       irq_mask;
    logic       illegal;
    logic [3:0] count;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       IRQ, mem_ready, branch_taken;
  logic       PCWrite, IorD, IRWrite, RegWrite, MemRead, MemWrite;
  logic [2:0] PCSrc;
  logic [1:0] RegDst, MemToReg;
  logic       ALUSrc1, ALUSrc2, ExtOp, LuOp;
  logic [2:0] ALUOp;
  logic       irq_mask, illegal;
  logic [3:0] instr_count;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  e;

  multicycle_controller #(.ALUOP_W(3), .CNT_W(4), .USE_MEM_READY(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .OpCode       (OpCode),
    .Funct        (Funct),
    .IRQ          (IRQ),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .PCWrite      (PCWrite),
    .PCSrc        (PCSrc),
    .IorD         (IorD),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .RegDst       (RegDst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemToReg     (MemToReg),
    .ALUSrc1      (ALUSrc1),
    .ALUSrc2      (ALUSrc2),
    .ExtOp        (ExtOp),
    .LuOp         (LuOp),
    .ALUOp        (ALUOp),
    .irq_mask     (irq_mask),
    .illegal      (illegal),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t base(input int cnt, input bit m);
    obs_t o = '0;
    o.count    = 4'(cnt);
    o.irq_mask = m;
    return o;
  endfunction

  function automatic obs_t f_if(input int cnt, input bit m, input bit rdy);
    obs_t o = base(cnt, m);
    o.mem_read = 1'b1;
    o.ir_write = rdy;
    o.pc_write = rdy;
    return o;
  endfunction

  function automatic obs_t dec(input int cnt, input bit m, input logic [2:0] aop,
                               input bit s1, input bit s2, input bit ext, input bit lu);
    obs_t o = base(cnt, m);
    o.alu_op   = aop;
    o.alu_src1 = s1;
    o.alu_src2 = s2;
    o.ext_op   = ext;
    o.lu_op    = lu;
    return o;
  endfunction

  function automatic obs_t irq_entry(input int cnt);
    obs_t o = base(cnt, 1'b0);
    o.reg_write  = 1'b1;
    o.reg_dst    = 2'b11;
    o.mem_to_reg = 2'b10;
    o.pc_write   = 1'b1;
    o.pc_src     = 3'b100;
    return o;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic rdy, input logic irq_in);
    OpCode    = op;
    Funct     = fn;
    mem_ready = rdy;
    IRQ       = irq_in;
  endtask

  task automatic checkOutput(input string name, input obs_t expv);
    obs_t act;
    act.pc_write   = PCWrite;
    act.pc_src     = PCSrc;
    act.iord       = IorD;
    act.ir_write   = IRWrite;
    act.reg_write  = RegWrite;
    act.reg_dst    = RegDst;
    act.mem_read   = MemRead;
    act.mem_write  = MemWrite;
    act.mem_to_reg = MemToReg;
    act.alu_src1   = ALUSrc1;
    act.alu_src2   = ALUSrc2;
    act.ext_op     = ExtOp;
    act.lu_op      = LuOp;
    act.alu_op     = ALUOp;
    act.irq_mask   = irq_mask;
    act.illegal    = illegal;
    act.count      = instr_count;
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic pushExpect(input string name, input obs_t expv);
    exp_q.push_back(expv);
    name_q.push_back(name);
  endtask

  task automatic expectCycle(input string name, input obs_t expv);
    pushExpect(name, expv);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the oldest queued expectation mid-cycle.
  initial begin
    obs_t  m_exp;
    string m_name;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        checkOutput(m_name, m_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    branch_taken = 1'b0;
    applyStimulus(6'h00, 6'h20, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expectCycle("reset_hold", '0);
    reset = 1'b1;

    // add: IF ID EX WB
    expectCycle("add_if", f_if(0, 0, 1));
    expectCycle("add_id", dec(0, 0, 3'd2, 0, 0, 1, 0));
    expectCycle("add_ex", dec(0, 0, 3'd2, 0, 0, 1, 0));
    e = dec(0, 0, 3'd2, 0, 0, 1, 0); e.reg_write = 1; e.reg_dst = 2'b01;
    expectCycle("add_wb", e);

    // lw with two MEM wait states
    applyStimulus(6'h23, 6'h00, 1'b1, 1'b0);
    expectCycle("lw_if", f_if(1, 0, 1));
    expectCycle("lw_id", dec(1, 0, 3'd0, 0, 1, 1, 0));
    expectCycle("lw_ex", dec(1, 0, 3'd0, 0, 1, 1, 0));
    e = dec(1, 0, 3'd0, 0, 1, 1, 0); e.iord = 1; e.mem_read = 1;
    mem_ready = 1'b0;
    expectCycle("lw_mem_wait1", e);
    expectCycle("lw_mem_wait2", e);
    mem_ready = 1'b1;
    expectCycle("lw_mem_done", e);
    e = dec(1, 0, 3'd0, 0, 1, 1, 0); e.reg_write = 1; e.mem_to_reg = 2'b01;
    expectCycle("lw_wb", e);

    // beq taken, with one IF wait state first
    applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
    branch_taken = 1'b1;
    expectCycle("beq_if_wait", f_if(2, 0, 0));
    mem_ready = 1'b1;
    expectCycle("beq_if", f_if(2, 0, 1));
    expectCycle("beq_id", dec(2, 0, 3'd1, 0, 0, 1, 0));
    e = dec(2, 0, 3'd1, 0, 0, 1, 0); e.pc_write = 1; e.pc_src = 3'b001;
    expectCycle("beq_ex_taken", e);

    // beq not taken
    branch_taken = 1'b0;
    expectCycle("beqn_if", f_if(3, 0, 1));
    expectCycle("beqn_id", dec(3, 0, 3'd1, 0, 0, 1, 0));
    e = dec(3, 0, 3'd1, 0, 0, 1, 0); e.pc_src = 3'b001;
    expectCycle("beqn_ex", e);

    // ori with IRQ raised mid-instruction
    applyStimulus(6'h0d, 6'h00, 1'b1, 1'b0);
    expectCycle("ori_if", f_if(4, 0, 1));
    IRQ = 1'b1;
    expectCycle("ori_id", dec(4, 0, 3'd4, 0, 1, 0, 0));
    expectCycle("ori_ex", dec(4, 0, 3'd4, 0, 1, 0, 0));
    e = dec(4, 0, 3'd4, 0, 1, 0, 0); e.reg_write = 1;
    expectCycle("ori_wb", e);
    expectCycle("irq_entry", irq_entry(5));

    // j inside the handler: IRQ still high but masked
    applyStimulus(6'h02, 6'h00, 1'b1, 1'b1);
    expectCycle("j_if_masked", f_if(5, 1, 1));
    e = dec(5, 1, 3'd0, 0, 0, 1, 0); e.pc_write = 1; e.pc_src = 3'b010;
    expectCycle("j_id", e);

    // jr with IRQ still high: mask clears and the IRQ is re-entered
    applyStimulus(6'h00, 6'h08, 1'b1, 1'b1);
    expectCycle("jr1_if", f_if(6, 1, 1));
    expectCycle("jr1_id", dec(6, 1, 3'd2, 0, 0, 1, 0));
    e = dec(6, 1, 3'd2, 0, 0, 1, 0); e.pc_write = 1; e.pc_src = 3'b011;
    expectCycle("jr1_ex", e);
    IRQ = 1'b0;
    expectCycle("irq_reentry", irq_entry(7));

    // jr with IRQ low: returns and clears the mask
    expectCycle("jr2_if", f_if(7, 1, 1));
    expectCycle("jr2_id", dec(7, 1, 3'd2, 0, 0, 1, 0));
    e = dec(7, 1, 3'd2, 0, 0, 1, 0); e.pc_write = 1; e.pc_src = 3'b011;
    expectCycle("jr2_ex", e);

    // illegal opcode 3f
    applyStimulus(6'h3f, 6'h00, 1'b1, 1'b0);
    expectCycle("ill_if", f_if(8, 0, 1));
    e = base(8, 0); e.illegal = 1;
    expectCycle("ill_id", e);

    // jal
    applyStimulus(6'h03, 6'h00, 1'b1, 1'b0);
    expectCycle("jal_if", f_if(8, 0, 1));
    e = dec(8, 0, 3'd0, 0, 0, 1, 0); e.pc_write = 1; e.pc_src = 3'b010;
    e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
    expectCycle("jal_id", e);

    applyStimulus(6'h00, 6'h00, 1'b1, 1'b0);
    expectCycle("cnt_after_jal", f_if(9, 0, 1));
    reset = 1'b0;
    expectCycle("reset_mid", '0);
    reset = 1'b1;

    // 16 nops (sll) wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      expectCycle("nop_if", f_if(k, 0, 1));
      expectCycle("nop_id", dec(k, 0, 3'd2, 1, 0, 1, 0));
      expectCycle("nop_ex", dec(k, 0, 3'd2, 1, 0, 1, 0));
      e = dec(k, 0, 3'd2, 1, 0, 1, 0); e.reg_write = 1; e.reg_dst = 2'b01;
      expectCycle("nop_wb", e);
    end

    // sw aborted by reset while waiting in MEM
    applyStimulus(6'h2b, 6'h00, 1'b1, 1'b0);
    expectCycle("sw_if_wrapped", f_if(0, 0, 1));
    expectCycle("sw_id", dec(0, 0, 3'd0, 0, 1, 1, 0));
    expectCycle("sw_ex", dec(0, 0, 3'd0, 0, 1, 1, 0));
    mem_ready = 1'b0;
    e = dec(0, 0, 3'd0, 0, 1, 1, 0); e.iord = 1; e.mem_write = 1;
    pushExpect("sw_mem_wait", e);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("sw_reset_abort", '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    expectCycle("post_reset_if", f_if(0, 0, 1));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle MIPS control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath strobes for each phase. It sits beside the shared-memory multi-cycle datapath, which it also serves as memory handshake master. It generalises the single-cycle decoder in four ways: configurable memory wait states, a configurable ALU-op width, an interrupt entry/return mechanism, and a retired-instruction counter.

## Interface
Parameters:
- ALUOP_W, 3: width of ALUOp (must be ≥3).
- CNT_W, 32: width of retired-instruction counter.
- USE_MEM_READY, 1: 1 = memory phases wait for mem_ready; 0 = mem_ready ignored, every access completes in 1 cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OpCode  in  6  IR[31:26], valid from ID onward.
- Funct  in  6  IR[5:0].
- IRQ  in  1  level interrupt request.
- mem_ready  in  1  memory access completes this cycle.
- branch_taken  in  1  ALU branch condition, valid in EX.
- PCWrite  out  1  load PC.
- PCSrc  out  3  000 PC+4, 001 branch target, 010 jump target, 011 register (jr), 100 IRQ vector.
- IorD  out  1  memory address from ALUOut (1) or PC (0).
- IRWrite  out  1  load instruction register.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $31, 11 $26.
- MemRead, MemWrite  out  1 each  memory strobes.
- MemToReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrc1  out  1  1 = shamt (sll/srl/sra).
- ALUSrc2  out  1  1 = extended immediate.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend (andi/ori only).
- LuOp  out  1  1 for lui.
- ALUOp  out  ALUOP_W  0 add, 1 sub, 2 R-type/funct, 3 and, 4 or, 5 slt, 6 sltu, 7 pass-upper.
- irq_mask  out  1  set while an interrupt handler runs.
- illegal  out  1  one-cycle pulse in ID for an unsupported opcode.
- instr_count  out  CNT_W  retired instructions.

## Operation
- States: IF, ID, EX, MEM, WB, IRQ.
- Supported opcodes: 00, 01, 02–0d, 0f, 23, 2b. All others are illegal.

Per-state behaviour:
- IF: MemRead=1, IorD=0. When mem_ready (or always if USE_MEM_READY=0): IRWrite=1, PCWrite=1 (PCSrc=000), go to ID. Otherwise hold in IF with IRWrite=PCWrite=0.
- ID, j: PCWrite, PCSrc=010, go to IF.
- ID, jal: PCWrite (PCSrc=010), plus RegWrite with RegDst=10 and MemToReg=10, go to IF.
- ID, illegal: pulse illegal, no writes, go to IF.
- ID, all others: go to EX.
- EX, branch (01, 04–07): ALUOp=1. If branch_taken, PCWrite with PCSrc=001. Go to IF.
- EX, jr/jalr: PCWrite, PCSrc=011. jalr also writes rd with MemToReg=10. jr additionally clears irq_mask. Go to IF.
- EX, lw/sw: ALUSrc2=1, ALUOp=0, go to MEM.
- EX, other R-type and I-type ALU: go to WB.
- MEM: IorD=1; MemRead for lw, MemWrite for sw. Wait for mem_ready. lw then goes to WB; sw then goes to IF.
- WB: RegWrite=1. RegDst=01 for R-type, 00 otherwise. MemToReg=01 for lw, 00 otherwise. Go to IF.
- Interrupt check: on any transition into IF, if IRQ=1 and irq_mask=0, go to IRQ instead.
- IRQ state: RegWrite, RegDst=11, MemToReg=10 (saves PC into $26); PCWrite, PCSrc=100; set irq_mask; go to IF.
- instr_count increments by 1 on every completed non-illegal instruction (the transition out of its final state). The IRQ state does not count. The counter wraps modulo 2^CNT_W.
- Decode signals (ALUOp, ALUSrc*, ExtOp, LuOp) are driven from OpCode/Funct in the ID, EX, MEM and WB states. They are 0 in IF and IRQ.

## Timing
- Reset (asynchronous, reset=0): state=IF, irq_mask=0, instr_count=0. While reset is low, every strobe output is forced to 0. Reset asserted mid-instruction aborts it immediately.
- Outputs are combinational from state, OpCode, Funct and handshake inputs. state, irq_mask and instr_count are registered.
- Cycle counts with zero wait states: j/jal 2, branch/jr/jalr 3, ALU 4, sw 4, lw 5, interrupt entry +1.
- Each wait cycle on mem_ready adds 1 cycle in IF or MEM. Outputs hold stable while waiting.
- IRQ arriving during an instruction is sampled only at that instruction's boundary.
- IRQ held high with irq_mask=1 is ignored until jr clears the mask. If IRQ is still high at the boundary after that jr, the IRQ state is entered again.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum;
  - opcode/funct constants;
  - PCSrc, RegDst, MemToReg and ALUOp encodings.
- One sub-module, ctrl_decode: combinational OpCode/Funct classifier. It produces is_rtype, is_branch, is_load, is_store, is_jump, is_jal, is_jr, is_jalr, is_shift, illegal, ALUOp, ExtOp and LuOp.
- The FSM, irq_mask and instr_count live in multicycle_controller.

## Test plan
- Reset release, then add (00/20) with mem_ready=1: IF, ID, EX, WB over 4 cycles. WB shows RegWrite=1, RegDst=01. instr_count=1.
- lw (23) with mem_ready low for 2 cycles in MEM: total 7 cycles. MemRead and IorD=1 held for 3 MEM cycles. WB shows MemToReg=01.
- beq (04) with branch_taken=1: PCWrite with PCSrc=001 in EX. With branch_taken=0: no PCWrite in EX. Both cases take 3 cycles.
- IRQ=1 during ori (0d): ori completes, then the IRQ state writes $26 (RegDst=11) with PCSrc=100 and irq_mask=1. A subsequent jr (00/08) clears irq_mask.
- Opcode 3f: illegal pulses for 1 cycle, no RegWrite/MemWrite, back to IF, instr_count unchanged.
- CNT_W=4: 16 nops wrap instr_count to 0. Asserting reset during MEM of an sw drops MemWrite to 0 asynchronously.
